// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the programmable sequence detector: segment layout and hex glyphs.
package seq_detector_param_pkg;

  localparam int         SEG_DP  = 7;
  localparam logic [7:0] SEG_RST = 8'h3F;

  // Standard active-high glyphs, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bit-stream, configuration and result signals of the sequence detector.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 4
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               ena;
  logic               bit_in;
  logic               bit_valid;
  logic               overlap;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic [7:0]         seg;

  modport master (output ena, bit_in, bit_valid, overlap, cfg_we, cfg_pat, cfg_len, cnt_clr,
                  input  match, match_cnt, seg);
  modport slave  (input  ena, bit_in, bit_valid, overlap, cfg_we, cfg_pat, cfg_len, cnt_clr,
                  output match, match_cnt, seg);
endinterface

// File: rtl/seq_detector_param_hex_to_7seg.sv
// Combinational 4-bit to 7-segment glyph decoder.
module hex_to_7seg
  import seq_detector_param_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex_glyph(val_i);
endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with saturating match counter and 7-seg display.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 4,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(3),
  parameter int                 RST_LEN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_detector_param_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_nxt, mask;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d;
  logic [LEN_W:0]     fill_p1;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d;
  logic [7:0]         seg_q, seg_d;
  logic [6:0]         glyph;
  logic               accept, cfg_ok, hit;

  assign accept   = bus.ena & bus.bit_valid & ~bus.cfg_we;
  assign cfg_ok   = bus.ena & bus.cfg_we & (bus.cfg_len != '0) & (bus.cfg_len <= LEN_W'(MAX_LEN));
  assign hist_nxt = {hist_q[MAX_LEN-2:0], bus.bit_in};
  assign fill_p1  = {1'b0, fill_q} + (LEN_W+1)'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
  end

  // fill tracks how many bits of hist are eligible; it gates matches after clears
  assign hit = accept & (fill_p1 >= {1'b0, len_q}) & (((hist_nxt ^ pat_q) & mask) == '0);

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (cfg_ok) begin
      pat_d  = bus.cfg_pat;
      len_d  = bus.cfg_len;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = hist_nxt;
      fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
      if (hit && !bus.overlap) fill_d = '0;
    end
    if (bus.cnt_clr)               cnt_d = '0;
    else if (hit && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
    match_d = hit;
    seg_d   = {hit, glyph};
  end

  // Display follows the counter value being written this edge
  hex_to_7seg u_hex (.val_i(cnt_d[3:0]), .seg_o(glyph));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= RST_PAT;
      len_q   <= LEN_W'(RST_LEN);
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      seg_q   <= SEG_RST;
    end else if (bus.ena) begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.seg       = seg_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_seq_detector_param;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();
  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .RST_PAT(8'h03), .RST_LEN(3))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] GL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference: the bits received since the last clear, plus current pattern and count
  bit                 mq[$];
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len, m_cnt;
  bit                 m_match;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pat = 8'h03; m_len = 3; m_cnt = 0; m_match = 0;
  endtask

  task automatic model_step(input bit ena, bv, b, ov, we, input logic [MAX_LEN-1:0] pat,
                            input int len, input bit clr);
    bit hit = 0;
    if (!ena) return;
    if (we) begin
      if (len >= 1 && len <= MAX_LEN) begin m_pat = pat; m_len = len; mq.delete(); end
    end else if (bv) begin
      mq.push_back(b);
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
      if (mq.size() >= m_len) begin
        hit = 1;
        for (int k = 0; k < m_len; k++)
          if (mq[mq.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
      end
      if (hit && !ov) mq.delete();
    end
    if (clr)                       m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    m_match = hit;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".match"}, bus.match, m_match);
    chk({tag, ".cnt"},   bus.match_cnt, m_cnt);
    chk({tag, ".seg"},   bus.seg, {m_match, GL[m_cnt & 15]});
  endtask

  // One clock with the given inputs; outputs sampled 1ns after the edge
  task automatic cyc(input bit ena, bv, b, ov, we, input logic [MAX_LEN-1:0] pat,
                     input int len, input bit clr);
    bus.ena = ena; bus.bit_valid = bv; bus.bit_in = b; bus.overlap = ov;
    bus.cfg_we = we; bus.cfg_pat = pat; bus.cfg_len = LEN_W'(len); bus.cnt_clr = clr;
    model_step(ena, bv, b, ov, we, pat, len, clr);
    @(posedge clk); #1;
  endtask

  task automatic bitc(input bit b, input bit ov);
    cyc(1, 1, b, ov, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    bus.ena = 0; bus.bit_valid = 0; bus.bit_in = 0; bus.overlap = 1;
    bus.cfg_we = 0; bus.cfg_pat = '0; bus.cfg_len = '0; bus.cnt_clr = 0;
    @(negedge clk); rst_n = 0; model_reset();
    @(negedge clk); rst_n = 1;
  endtask

  typedef struct {
    bit ena, bv, b, clr;
    bit em; int ecnt; logic [7:0] eseg;
  } vec_t;
  vec_t tbl[10];

  int nm;

  initial begin
    tbl[0] = '{1, 1, 0, 0, 0, 0, 8'h3F};
    tbl[1] = '{1, 1, 1, 0, 0, 0, 8'h3F};
    tbl[2] = '{1, 1, 1, 0, 1, 1, 8'h86};
    tbl[3] = '{1, 1, 1, 0, 0, 1, 8'h06};
    tbl[4] = '{0, 1, 0, 0, 0, 1, 8'h06};
    tbl[5] = '{1, 1, 0, 0, 0, 1, 8'h06};
    tbl[6] = '{1, 0, 1, 0, 0, 1, 8'h06};
    tbl[7] = '{1, 1, 1, 0, 0, 1, 8'h06};
    tbl[8] = '{1, 1, 1, 0, 1, 2, 8'hDB};
    tbl[9] = '{1, 1, 1, 1, 0, 0, 8'h3F};

    rst_n = 1;
    do_reset();
    chk("rst.match", bus.match, 0);
    chk("rst.cnt",   bus.match_cnt, 0);
    chk("rst.seg",   bus.seg, 8'h3F);

    // Default "011" detection and basic gating
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].ena, tbl[i].bv, tbl[i].b, 1, 0, '0, 0, tbl[i].clr);
      chk($sformatf("tbl%0d.match", i), bus.match, tbl[i].em);
      chk($sformatf("tbl%0d.cnt", i),   bus.match_cnt, tbl[i].ecnt);
      chk($sformatf("tbl%0d.seg", i),   bus.seg, tbl[i].eseg);
    end

    // Pattern 1010, overlapping then non-overlapping
    cyc(1, 0, 0, 1, 1, 8'h0A, 4, 1);
    nm = 0;
    for (int i = 0; i < 6; i++) begin
      bitc((i % 2) == 0, 1);
      check_model("ovl");
      nm += int'(bus.match);
    end
    chk("ovl.matches", nm, 2);
    chk("ovl.cnt", bus.match_cnt, 2);
    cyc(1, 0, 0, 0, 1, 8'h0A, 4, 1);
    nm = 0;
    for (int i = 0; i < 6; i++) begin
      bitc((i % 2) == 0, 0);
      check_model("novl");
      nm += int'(bus.match);
    end
    chk("novl.matches", nm, 1);
    chk("novl.cnt", bus.match_cnt, 1);

    // Saturation, then clear beating a same-cycle hit
    do_reset();
    for (int i = 0; i < 17; i++) begin bitc(0, 1); bitc(1, 1); bitc(1, 1); end
    chk("sat.cnt", bus.match_cnt, 15);
    chk("sat.seg", bus.seg[6:0], 7'h71);
    bitc(0, 1); bitc(1, 1);
    cyc(1, 1, 1, 1, 0, '0, 0, 1);
    chk("clrhit.match", bus.match, 1);
    chk("clrhit.cnt", bus.match_cnt, 0);
    chk("clrhit.seg", bus.seg, 8'hBF);

    // Config write drops the same-cycle bit and clears history
    bitc(0, 1); bitc(1, 1);
    cyc(1, 1, 1, 1, 1, 8'h03, 3, 0);
    chk("cfgdrop.match", bus.match, 0);
    nm = 0;
    bitc(0, 1); nm += int'(bus.match);
    bitc(1, 1); nm += int'(bus.match);
    bitc(1, 1); nm += int'(bus.match);
    check_model("cfgdrop");
    chk("cfgdrop.matches", nm, 1);

    // Asynchronous reset mid-sequence
    bitc(0, 1); bitc(1, 1);
    #3 rst_n = 0; model_reset();
    #1;
    chk("arst.match", bus.match, 0);
    chk("arst.cnt", bus.match_cnt, 0);
    chk("arst.seg", bus.seg, 8'h3F);
    #1 rst_n = 1;
    bitc(1, 1);
    chk("arst.nomatch", bus.match, 0);
    chk("arst.cnt2", bus.match_cnt, 0);
    chk("arst.seg2", bus.seg, 8'h3F);

    // Out-of-range lengths are ignored entirely
    cyc(1, 0, 0, 1, 1, 8'hFF, 0, 0);
    cyc(1, 0, 0, 1, 1, 8'hFF, MAX_LEN + 1, 0);
    bitc(0, 1); bitc(1, 1); bitc(1, 1);
    chk("badlen.match", bus.match, 1);
    check_model("badlen");

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      bit we = ($urandom_range(0, 19) == 0);
      int len = ($urandom_range(0, 7) == 0) ? MAX_LEN + 1 : int'($urandom_range(0, 5));
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
          we, MAX_LEN'($urandom), len, $urandom_range(0, 39) == 0);
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
